// File: rtl/audio_clk_mux_pkg.sv
// -----------------------------------------------------------------------------
// audio_clk_mux_pkg
// Shared definitions for the audio master-clock source switch controller:
//   - default phase lengths (mute hold, settle, ack timeout) in clkb_clkin cycles
//   - the switch sequencer state encoding
//   - cnt_width(): width of the shared phase counter, sized so the largest
//     phase length minus one always fits, with one bit of headroom
// No ports (package).
// -----------------------------------------------------------------------------
package audio_clk_mux_pkg;

   localparam int DEF_MUTE_CYCLES    = 64;
   localparam int DEF_SETTLE_CYCLES  = 256;
   localparam int DEF_TIMEOUT_CYCLES = 4096;

   // Sequencer states. Encoding is fixed so the state can be probed on a
   // debug bus and decoded by hand.
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_MUTE_WAIT = 3'd1,
      ST_DISABLE   = 3'd2,
      ST_ENABLE    = 3'd3,
      ST_SETTLE    = 3'd4,
      ST_FAULT     = 3'd5
   } sw_state_t;

   // Counter width: $clog2 of the largest phase length, plus one bit.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/audio_clk_sw_timer.sv
// -----------------------------------------------------------------------------
// audio_clk_sw_timer
// Loadable down-counter with a zero flag. One instance times every phase of the
// clock switch sequence (mute hold, ack timeouts, settle).
// Ports:
//   clk       in  counter clock (rising edge)
//   rst_n     in  asynchronous active-low reset, loads RESET_VAL
//   load      in  load load_val this edge (has priority over dec)
//   load_val  in  value to load
//   dec       in  decrement this edge; holds at zero, never wraps
//   zero      out count == 0
// -----------------------------------------------------------------------------
module audio_clk_sw_timer
   import audio_clk_mux_pkg::*;
#(
   parameter int               WIDTH     = cnt_width(DEF_MUTE_CYCLES,
                                                     DEF_SETTLE_CYCLES,
                                                     DEF_TIMEOUT_CYCLES),
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [WIDTH-1:0] count;

   // Load wins over decrement; a decrement at zero is ignored so the zero
   // flag stays asserted until the next load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= RESET_VAL;
      end else if (load) begin
         count <= load_val;
      end else if (dec && !zero) begin
         count <= count - WIDTH'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/audio_clk_switch_ctrl.sv
// -----------------------------------------------------------------------------
// audio_clk_switch_ctrl
// Glitch-safe sequencer for switching the audio master clock between two
// sources (clk1 = 48k family, clk2 = 44.1k family). A change is performed as:
// mute the datapath, hold mute, gate off the old source, wait for its running
// ack to drop, gate on the new source, wait for its ack, let it settle, unmute.
// The two source enables are never high together. A missing ack edge within
// TIMEOUT_CYCLES parks the block in a fault state with both sources gated off
// and a sticky err flag; a new request from there restarts directly at the
// enable phase of the requested source.
//
// Coming out of reset the block brings up clk1 (enable phase, target 0), so
// the first unmute happens SETTLE_CYCLES after ack1 is seen.
//
// The ack inputs must already be synchronized to clkb_clkin.
// All phase lengths must be >= 1; a value of 1 gives a single-cycle phase.
//
// Ports:
//   clkb_clkin  in   sole clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   req_valid   in   source change request valid
//   req_sel     in   requested source (0 = clk1, 1 = clk2)
//   req_ready   out  request accepted on an edge with req_valid & req_ready
//   ack1_sync   in   clk1 running ack (synchronized)
//   ack2_sync   in   clk2 running ack (synchronized)
//   clk1_en     out  enable to clk1 source gate
//   clk2_en     out  enable to clk2 source gate
//   mute        out  audio mute to datapath
//   cur_sel     out  active source, meaningful while busy = 0
//   busy        out  switch sequence in progress
//   err         out  sticky ack-timeout flag
// -----------------------------------------------------------------------------
module audio_clk_switch_ctrl
   import audio_clk_mux_pkg::*;
#(
   parameter int MUTE_CYCLES    = DEF_MUTE_CYCLES,
   parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic clkb_clkin,
   input  logic reset_n,
   input  logic req_valid,
   input  logic req_sel,
   output logic req_ready,
   input  logic ack1_sync,
   input  logic ack2_sync,
   output logic clk1_en,
   output logic clk2_en,
   output logic mute,
   output logic cur_sel,
   output logic busy,
   output logic err
);

   localparam int CNT_W = cnt_width(MUTE_CYCLES, SETTLE_CYCLES, TIMEOUT_CYCLES);

   localparam logic [CNT_W-1:0] MUTE_LOAD    = CNT_W'(MUTE_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

   sw_state_t  state;
   sw_state_t  state_nxt;
   logic       target;
   logic       target_nxt;
   logic       clk1_en_nxt;
   logic       clk2_en_nxt;
   logic       mute_nxt;
   logic       cur_sel_nxt;
   logic       err_nxt;
   logic       go_fault;

   logic             tmr_load;
   logic [CNT_W-1:0] tmr_val;
   logic             tmr_dec;
   logic             tmr_zero;

   logic accept;
   logic old_ack;
   logic tgt_ack;

   // Requests are only taken in IDLE and FAULT; anything presented while a
   // sequence runs is simply not acknowledged and therefore not queued.
   assign req_ready = (state == ST_IDLE) || (state == ST_FAULT);
   assign busy      = !req_ready;
   assign accept    = req_valid && req_ready;

   // cur_sel still names the outgoing source until the new one acks, so it
   // selects the "old" ack during DISABLE.
   assign old_ack = cur_sel ? ack2_sync : ack1_sync;
   assign tgt_ack = target  ? ack2_sync : ack1_sync;

   audio_clk_sw_timer #(
      .WIDTH     (CNT_W),
      .RESET_VAL (TIMEOUT_LOAD)
   ) u_timer (
      .clk      (clkb_clkin),
      .rst_n    (reset_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .dec      (tmr_dec),
      .zero     (tmr_zero)
   );

   // Next-state and next-output logic. Ack conditions are tested before the
   // timeout so an ack that is already in the wanted level advances on the
   // first cycle in the state, and an ack arriving on the very last timeout
   // cycle still counts as success. Every phase exit reloads the timer for
   // the following phase.
   always_comb begin
      state_nxt   = state;
      target_nxt  = target;
      clk1_en_nxt = clk1_en;
      clk2_en_nxt = clk2_en;
      mute_nxt    = mute;
      cur_sel_nxt = cur_sel;
      err_nxt     = err;
      go_fault    = 1'b0;
      tmr_load    = 1'b0;
      tmr_val     = '0;
      tmr_dec     = 1'b0;

      case (state)
         ST_IDLE: begin
            if (accept && (req_sel != cur_sel)) begin
               target_nxt = req_sel;
               mute_nxt   = 1'b1;
               tmr_load   = 1'b1;
               tmr_val    = MUTE_LOAD;
               state_nxt  = ST_MUTE_WAIT;
            end
         end

         ST_MUTE_WAIT: begin
            if (tmr_zero) begin
               if (cur_sel) clk2_en_nxt = 1'b0;
               else         clk1_en_nxt = 1'b0;
               tmr_load  = 1'b1;
               tmr_val   = TIMEOUT_LOAD;
               state_nxt = ST_DISABLE;
            end else begin
               tmr_dec = 1'b1;
            end
         end

         ST_DISABLE: begin
            if (!old_ack) begin
               // Old enable is already low here, so driving both from the
               // target only ever raises the new one.
               clk1_en_nxt = !target;
               clk2_en_nxt = target;
               tmr_load    = 1'b1;
               tmr_val     = TIMEOUT_LOAD;
               state_nxt   = ST_ENABLE;
            end else if (tmr_zero) begin
               go_fault = 1'b1;
            end else begin
               tmr_dec = 1'b1;
            end
         end

         ST_ENABLE: begin
            if (tgt_ack) begin
               cur_sel_nxt = target;
               err_nxt     = 1'b0;
               tmr_load    = 1'b1;
               tmr_val     = SETTLE_LOAD;
               state_nxt   = ST_SETTLE;
            end else if (tmr_zero) begin
               go_fault = 1'b1;
            end else begin
               tmr_dec = 1'b1;
            end
         end

         ST_SETTLE: begin
            if (tmr_zero) begin
               mute_nxt  = 1'b0;
               state_nxt = ST_IDLE;
            end else begin
               tmr_dec = 1'b1;
            end
         end

         ST_FAULT: begin
            // Both enables are low in FAULT, so the requested source can be
            // raised immediately; the old source needs no disable phase.
            if (accept) begin
               target_nxt  = req_sel;
               clk1_en_nxt = !req_sel;
               clk2_en_nxt = req_sel;
               tmr_load    = 1'b1;
               tmr_val     = TIMEOUT_LOAD;
               state_nxt   = ST_ENABLE;
            end
         end

         default: begin
            go_fault = 1'b1;
         end
      endcase

      if (go_fault) begin
         clk1_en_nxt = 1'b0;
         clk2_en_nxt = 1'b0;
         mute_nxt    = 1'b1;
         err_nxt     = 1'b1;
         state_nxt   = ST_FAULT;
      end
   end

   // State and output registers. Reset abandons any sequence at once and
   // starts a clk1 bring-up: clk1 gated on, muted, waiting for ack1.
   always_ff @(posedge clkb_clkin or negedge reset_n) begin
      if (!reset_n) begin
         state   <= ST_ENABLE;
         target  <= 1'b0;
         clk1_en <= 1'b1;
         clk2_en <= 1'b0;
         mute    <= 1'b1;
         cur_sel <= 1'b0;
         err     <= 1'b0;
      end else begin
         state   <= state_nxt;
         target  <= target_nxt;
         clk1_en <= clk1_en_nxt;
         clk2_en <= clk2_en_nxt;
         mute    <= mute_nxt;
         cur_sel <= cur_sel_nxt;
         err     <= err_nxt;
      end
   end

endmodule

// File: doc/audio_clk_switch_ctrl.md
AUDIO_CLK_SWITCH_CTRL -- requirements
Module: audio_clk_switch_ctrl

Interface
REQ-001 Parameter MUTE_CYCLES, 64, cycles mute is held before any source change.
REQ-002 Parameter SETTLE_CYCLES, 256, cycles after new-source ack before unmute.
REQ-003 Parameter TIMEOUT_CYCLES, 4096, maximum cycles to wait for any ack edge.
REQ-004 clkb_clkin  in  1  sole clock; one clock, all logic on rising edge.
REQ-005 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-006 req_valid  in  1  source-change request valid.
REQ-007 req_sel  in  1  requested source (0 = clk1 / 48k family, 1 = clk2 / 44.1k family).
REQ-008 req_ready  out  1  request accepted when req_valid & req_ready on an edge.
REQ-009 ack1_sync  in  1  clk1 running ack, already synchronized to clkb_clkin.
REQ-010 ack2_sync  in  1  clk2 running ack, already synchronized to clkb_clkin.
REQ-011 clk1_en  out  1  enable to clk1 source gate.
REQ-012 clk2_en  out  1  enable to clk2 source gate.
REQ-013 mute  out  1  audio mute to datapath.
REQ-014 cur_sel  out  1  currently active source, valid when busy=0.
REQ-015 busy  out  1  switch sequence in progress.
REQ-016 err  out  1  sticky ack-timeout flag.

Function
REQ-017 FSM states SHALL be IDLE, MUTE_WAIT, DISABLE, ENABLE, SETTLE, FAULT.
REQ-018 IDLE: req_ready=1, busy=0, mute=0; accepted req with req_sel==cur_sel -> stay IDLE, no output change.
REQ-019 IDLE: accepted req with req_sel!=cur_sel -> latch target, mute=1, load counter MUTE_CYCLES-1, go MUTE_WAIT next edge.
REQ-020 MUTE_WAIT: decrement; at 0 deassert old source enable, load TIMEOUT_CYCLES-1, go DISABLE.
REQ-021 DISABLE: when old ack==0 assert target enable, reload timeout, go ENABLE; both enables never 1 simultaneously.
REQ-022 ENABLE: when target ack==1 set cur_sel=target, load SETTLE_CYCLES-1, go SETTLE.
REQ-023 SETTLE: decrement; at 0 clear mute, go IDLE; req_ready SHALL reassert that same edge.
REQ-024 Timeout in DISABLE or ENABLE: both enables 0, mute=1, err=1, go FAULT.
REQ-025 FAULT: busy=0, req_ready=1; any accepted req restarts at ENABLE for req_sel (skipping MUTE_WAIT), clears err on successful reach of SETTLE.
REQ-026 req_ready=0 in every state except IDLE and FAULT; requests while busy are not queued.
REQ-027 Counter SHALL be $clog2 of largest parameter +1 bits; parameters of 1 give single-cycle phases, 0 not allowed.
REQ-028 Ack inputs already toggling in wrong sense (e.g. old ack already 0 in DISABLE) SHALL advance on first cycle in state.

Reset
REQ-029 reset_n low: state ENABLE, target=0, clk1_en=1, clk2_en=0, mute=1, busy=1, cur_sel=0, err=0, req_ready=0, counter=TIMEOUT_CYCLES-1.
REQ-030 Reset mid-sequence SHALL abandon sequence immediately; after release bring-up of clk1 follows REQ-022/023.

Structure
REQ-031 Package audio_clk_mux_pkg SHALL hold FSM state enum and default parameter constants.
REQ-032 Sub-module audio_clk_sw_timer (loadable down-counter with zero flag) SHALL serve all timed phases.
REQ-033 Ack synchronization SHALL stay outside this block (existing two-clock syncro instance).

Verification
REQ-034 Reset release, ack1_sync rises cycle 10 -> mute falls exactly 256 cycles after cur_sel=0 registered, busy=0.
REQ-035 IDLE cur_sel=0, req_sel=1 -> mute 1 next edge; clk1_en 0 after 64 cycles; clk2_en 1 first cycle after ack1 low; mute 0 256 cycles after ack2 high; cur_sel=1.
REQ-036 Request req_sel=cur_sel in IDLE -> no output change, req_ready stays 1.
REQ-037 ack2_sync held 0 -> err=1, both enables 0, mute=1 at 4096 cycles into ENABLE; subsequent req_sel=0 with ack1 -> recovery, err=0.
REQ-038 reset_n pulse low during SETTLE -> clk2_en=0, clk1_en=1, mute=1 asynchronously, no enable overlap.
REQ-039 req_valid held 1 throughout a switch -> only one accept per sequence; assertion: clk1_en & clk2_en never 1.
